// File: rtl/ldm_stm_sequencer_if.sv
// rtl/ldm_stm_sequencer_if.sv - request, memory, register-file and writeback bundle for the LDM/STM sequencer
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_dec;
  logic              req_wb;
  logic [ADDR_W-1:0] req_base;
  logic [3:0]        req_base_reg;
  logic [15:0]       req_reglist;

  logic              mem_ldr_str_en;
  logic              mem_load_en;
  logic              mem_store_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_i;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [3:0]        rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [3:0]        rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [ADDR_W-1:0] wb_data;

  logic              busy;
  logic              done;

  modport master (
    input  req_valid, req_load, req_dec, req_wb, req_base, req_base_reg, req_reglist,
    input  mem_read_data, rf_rd_data,
    output req_ready,
    output mem_ldr_str_en, mem_load_en, mem_store_en, mem_addr, mem_i, mem_write_data,
    output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output wb_en, wb_addr, wb_data, busy, done
  );

  modport slave (
    output req_valid, req_load, req_dec, req_wb, req_base, req_base_reg, req_reglist,
    output mem_read_data, rf_rd_data,
    input  req_ready,
    input  mem_ldr_str_en, mem_load_en, mem_store_en, mem_addr, mem_i, mem_write_data,
    input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  wb_en, wb_addr, wb_data, busy, done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block-transfer initiator, one register per cycle lowest-first
module ldm_stm_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  ldm_stm_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, FIN = 2'd2} state_t;

  state_t            state;
  logic              load_q;
  logic              wb_en_q;
  logic [3:0]        base_reg_q;
  logic [15:0]       list_q;
  logic [4:0]        n_q;
  logic [4:0]        k_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wb_data_q;
  logic              wr_en_q;
  logic [3:0]        wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [4:0]        req_n;
  logic [3:0]        cur_r;
  logic              live;
  logic              xfer;
  logic              fin;
  logic              store_beat;

  function automatic logic [4:0] popcount16(input logic [15:0] l);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(l[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] l);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (l[i]) r = 4'(i);
    return r;
  endfunction

  assign req_n = popcount16(bus.req_reglist);
  assign cur_r = lowest_set(list_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
      list_q     <= '0;
      n_q        <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      wb_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_en_q   <= 1'b0;
          wr_addr_q <= '0;
          wr_data_q <= '0;
          if (bus.req_valid) begin
            load_q     <= bus.req_load;
            base_reg_q <= bus.req_base_reg;
            list_q     <= bus.req_reglist;
            n_q        <= req_n;
            k_q        <= '0;
            // Decrementing blocks start n words below the base so the lowest register still gets the lowest address.
            addr_q     <= bus.req_dec ? bus.req_base - ADDR_W'(req_n) : bus.req_base;
            wb_data_q  <= bus.req_dec ? bus.req_base - ADDR_W'(req_n) : bus.req_base + ADDR_W'(req_n);
            wb_en_q    <= bus.req_wb && (req_n != 5'd0) &&
                          !(bus.req_load && bus.req_reglist[bus.req_base_reg]);
            state      <= (req_n != 5'd0) ? XFER : FIN;
          end
        end
        XFER: begin
          list_q[cur_r] <= 1'b0;
          k_q           <= k_q + 5'd1;
          wr_en_q       <= load_q;
          wr_addr_q     <= load_q ? cur_r : 4'd0;
          wr_data_q     <= load_q ? bus.mem_read_data : '0;
          if (k_q == n_q - 5'd1) state <= FIN;
        end
        FIN: begin
          wr_en_q   <= 1'b0;
          wr_addr_q <= '0;
          wr_data_q <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is high, which also drops a load write still in flight.
  assign live       = !rst;
  assign xfer       = live && (state == XFER);
  assign fin        = live && (state == FIN);
  assign store_beat = xfer && !load_q;

  assign bus.req_ready      = live && (state == IDLE);
  assign bus.busy           = live && (state != IDLE);
  assign bus.done           = fin;

  assign bus.mem_ldr_str_en = xfer;
  assign bus.mem_load_en    = xfer && load_q;
  assign bus.mem_store_en   = store_beat;
  assign bus.mem_addr       = xfer ? addr_q : '0;
  assign bus.mem_i          = xfer ? {3'b000, k_q} : 8'd0;
  assign bus.mem_write_data = store_beat ? bus.rf_rd_data : '0;
  assign bus.rf_rd_addr     = store_beat ? cur_r : 4'd0;

  assign bus.rf_wr_en       = live && wr_en_q;
  assign bus.rf_wr_addr     = live ? wr_addr_q : 4'd0;
  assign bus.rf_wr_data     = live ? wr_data_q : '0;

  assign bus.wb_en          = fin && wb_en_q;
  assign bus.wb_addr        = (fin && wb_en_q) ? base_reg_q : 4'd0;
  assign bus.wb_data        = (fin && wb_en_q) ? wb_data_q : '0;
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - table-driven bench for ldm_stm_sequencer with memory and register-file models
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ldm_stm_sequencer_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  ldm_stm_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem   [256];
  logic [31:0] regs  [16];

  always_comb bus.mem_read_data = mem[8'(bus.mem_addr + bus.mem_i)];
  always_comb bus.rf_rd_data    = regs[bus.rf_rd_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'hA0 + 32'(i);
    end else if (bus.rf_wr_en) begin
      regs[bus.rf_wr_addr] <= bus.rf_wr_data;
    end
  end

  typedef struct {
    logic        load;
    logic        dec;
    logic        wb;
    logic [7:0]  base;
    logic [3:0]  base_reg;
    logic [15:0] reglist;
    int          n;
    logic [7:0]  addr;
    logic        wb_en;
    logic [7:0]  wb_data;
  } vec_t;

  vec_t tab [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_load     = v.load;
    bus.req_dec      = v.dec;
    bus.req_wb       = v.wb;
    bus.req_base     = v.base;
    bus.req_base_reg = v.base_reg;
    bus.req_reglist  = v.reglist;
  endtask

  task automatic run_req(input vec_t v, input bit hold, input vec_t nxt);
    int         rl[$];
    logic [7:0] ix;
    for (int i = 0; i < 16; i++) if (v.reglist[i]) rl.push_back(i);
    chk("pre_ready", 32'(bus.req_ready), 32'd1);
    drive_req(v);
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) drive_req(nxt);
    else bus.req_valid = 1'b0;
    for (int b = 0; b < v.n; b++) begin
      chk("beat_busy", 32'(bus.busy), 32'd1);
      chk("beat_ready", 32'(bus.req_ready), 32'd0);
      chk("beat_done", 32'(bus.done), 32'd0);
      chk("beat_en", 32'(bus.mem_ldr_str_en), 32'd1);
      chk("beat_load_en", 32'(bus.mem_load_en), 32'(v.load));
      chk("beat_store_en", 32'(bus.mem_store_en), 32'(!v.load));
      chk("beat_addr", 32'(bus.mem_addr), 32'(v.addr));
      chk("beat_i", 32'(bus.mem_i), 32'(b));
      if (!v.load) begin
        chk("store_rd_addr", 32'(bus.rf_rd_addr), 32'(rl[b]));
        chk("store_data", bus.mem_write_data, regs[rl[b]]);
        chk("store_no_wr", 32'(bus.rf_wr_en), 32'd0);
      end else if (b == 0) begin
        chk("load_first_no_wr", 32'(bus.rf_wr_en), 32'd0);
      end else begin
        ix = v.addr + 8'(b - 1);
        chk("load_wr_en", 32'(bus.rf_wr_en), 32'd1);
        chk("load_wr_addr", 32'(bus.rf_wr_addr), 32'(rl[b-1]));
        chk("load_wr_data", bus.rf_wr_data, mem[ix]);
      end
      @(negedge clk);
    end
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_busy", 32'(bus.busy), 32'd1);
    chk("fin_no_mem", 32'(bus.mem_ldr_str_en), 32'd0);
    chk("fin_wb_en", 32'(bus.wb_en), 32'(v.wb_en));
    if (v.wb_en) begin
      chk("fin_wb_addr", 32'(bus.wb_addr), 32'(v.base_reg));
      chk("fin_wb_data", 32'(bus.wb_data), 32'(v.wb_data));
    end
    if (v.load && v.n > 0) begin
      ix = v.addr + 8'(v.n - 1);
      chk("fin_wr_en", 32'(bus.rf_wr_en), 32'd1);
      chk("fin_wr_addr", 32'(bus.rf_wr_addr), 32'(rl[v.n-1]));
      chk("fin_wr_data", bus.rf_wr_data, mem[ix]);
    end else begin
      chk("fin_no_wr", 32'(bus.rf_wr_en), 32'd0);
    end
    @(negedge clk);
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_ready", 32'(bus.req_ready), 32'd1);
    chk("post_no_wr", 32'(bus.rf_wr_en), 32'd0);
    chk("post_no_wb", 32'(bus.wb_en), 32'd0);
  endtask

  initial begin
    vec_t mid;
    for (int a = 0; a < 256; a++) mem[a] = 32'h5000 + 32'(a);
    mem[6] = 32'h11;
    mem[7] = 32'h22;
    bus.req_valid = 1'b0;
    bus.req_load = 1'b0; bus.req_dec = 1'b0; bus.req_wb = 1'b0;
    bus.req_base = '0; bus.req_base_reg = '0; bus.req_reglist = '0;

    //            load  dec   wb    base   breg  list      n   addr   wb_en wb_data
    tab[0] = '{1'b0, 1'b0, 1'b1, 8'h04, 4'd5, 16'h000B, 3, 8'h04, 1'b1, 8'h07};
    tab[1] = '{1'b1, 1'b1, 1'b1, 8'h08, 4'd3, 16'h0006, 2, 8'h06, 1'b1, 8'h06};
    tab[2] = '{1'b1, 1'b0, 1'b1, 8'h20, 4'd4, 16'h0010, 1, 8'h20, 1'b0, 8'h21};
    tab[3] = '{1'b0, 1'b0, 1'b1, 8'h30, 4'd2, 16'h0000, 0, 8'h00, 1'b0, 8'h00};
    tab[4] = '{1'b0, 1'b1, 1'b1, 8'hFA, 4'd13, 16'hFFFF, 16, 8'hEA, 1'b1, 8'hEA};
    tab[5] = '{1'b1, 1'b0, 1'b0, 8'hFE, 4'd1, 16'h8001, 2, 8'hFE, 1'b0, 8'h00};
    tab[6] = '{1'b0, 1'b0, 1'b1, 8'hFF, 4'd7, 16'h0300, 2, 8'hFF, 1'b1, 8'h01};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_ldr_str_en), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.req_ready), 32'd1);
    chk("rel_busy", 32'(bus.busy), 32'd0);

    // Entry 4 keeps req_valid high through its busy window with entry 5 on the bus.
    for (int i = 0; i < 7; i++) run_req(tab[i], i == 4, tab[(i + 1) % 7]);

    mid = '{1'b1, 1'b0, 1'b0, 8'h10, 4'd0, 16'h00F0, 4, 8'h10, 1'b0, 8'h00};
    drive_req(mid);
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_beat0_addr", 32'(bus.mem_addr), 32'h10);
    @(negedge clk);
    chk("mid_beat1_i", 32'(bus.mem_i), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_en", 32'(bus.mem_ldr_str_en), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_busy", 32'(bus.busy), 32'd0);
    chk("after_rst_done", 32'(bus.done), 32'd0);
    chk("after_rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("after_rst_mem_en", 32'(bus.mem_ldr_str_en), 32'd0);
    chk("after_rst_ready", 32'(bus.req_ready), 32'd1);
    run_req(tab[1], 1'b0, tab[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
